// File: rtl/mine_quest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mine_quest_pkg
// Description : Shared constants and helpers for the Mine Quest design:
//               key count, key-conditioner timing defaults, counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mine_quest_pkg;

  // Number of DE-series pushbuttons handled by the key conditioner.
  localparam int NUM_KEYS = 4;

  // Timing defaults at 50 MHz: 20 ms debounce, 500 ms first repeat,
  // 100 ms between subsequent repeats.
  localparam int DEBOUNCE_CYCLES = 1000000;
  localparam int REPEAT_DELAY    = 25000000;
  localparam int REPEAT_PERIOD   = 5000000;

  // Larger of two integers, used to size a counter shared by two limits.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter whose largest value is max_val: $clog2(max_val)+1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val) + 1;
  endfunction

endpackage : mine_quest_pkg
`default_nettype wire

// File: rtl/key_debounce_one.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_one
// Description : One pushbutton: 2-flop synchronizer, counter debounce,
//               registered press/release pulses and auto-repeat strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_one
  import mine_quest_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = mine_quest_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = mine_quest_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = mine_quest_pkg::REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,     // raw button, active-low, asynchronous
  output logic level_o,     // debounced state, 1 = pressed
  output logic press_o,     // one-cycle pulse on accepted press
  output logic release_o,   // one-cycle pulse on accepted release
  output logic strobe_o     // press pulse or auto-repeat pulse
);

  // Debounce counter holds at most DEBOUNCE_CYCLES-1 before clearing.
  localparam int              DBW     = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           sync1_q;
  logic           sync2_q;
  logic [DBW-1:0] db_cnt_q;
  logic [DBW-1:0] db_cnt_d;
  logic           level_q;
  logic           level_d;
  logic           press_q;
  logic           release_q;
  logic           strobe_q;

  logic           raw_pressed;
  logic           differ;
  logic           accept;
  logic           press_d;
  logic           release_d;
  logic           rpt_d;

  assign raw_pressed = ~sync2_q;
  assign differ      = (raw_pressed != level_q);
  assign accept      = differ && (db_cnt_q == DB_LAST);
  assign press_d     = accept && !level_q;
  assign release_d   = accept && level_q;

  // Count consecutive disagreeing cycles; toggle the level once the run is long enough.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (differ) begin
      if (accept) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  // Synchronize the raw button, hold the accepted level and register the edge pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      strobe_q  <= press_d | rpt_d;
    end
  end

  if (REPEAT_DELAY > 0) begin : g_repeat
    // The counter restarts at every repeat, so it never exceeds the larger
    // limit (plus one on the release edge) before an explicit clear.
    localparam int             RW         = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0]  FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q;
    logic          rep_armed_q;   // first repeat already issued for this hold
    logic          fire;

    // Fire only while the key stays pressed through this edge.
    assign fire  = level_q && level_d &&
                   (rep_cnt_q == (rep_armed_q ? NEXT_LAST : FIRST_LAST));
    assign rpt_d = fire;

    // Measure hold time since the press pulse, restarting after each repeat.
    always_ff @(posedge clk_i) begin
      if (rst_i || press_d || !level_q) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end else if (fire) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b1;
      end else begin
        rep_cnt_q   <= rep_cnt_q + RW'(1);
      end
    end
  end else begin : g_no_repeat
    assign rpt_d = 1'b0;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign strobe_o  = strobe_q;

endmodule : key_debounce_one
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Conditions the raw DE-series KEY buttons for the game logic:
//               debounced levels, press/release pulses, auto-repeat strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
  import mine_quest_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = mine_quest_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = mine_quest_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = mine_quest_pkg::REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_strobe
);

  // Each button is conditioned by its own fully independent slice.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .clk_i     (CLOCK_50),
      .rst_i     (Reset),
      .key_n_i   (KEY[gi]),
      .level_o   (key_level[gi]),
      .press_o   (key_press[gi]),
      .release_o (key_release[gi]),
      .strobe_o  (key_strobe[gi])
    );
  end

endmodule : key_conditioner
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_conditioner
// Description : Directed self-checking bench for key_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, plus a
//               second instance with repeat disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_b;
  logic [3:0] level, press, rel, strobe;
  logic [3:0] level_b, press_b, rel_b, strobe_b;

  int checks;
  int errors;

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .KEY         (key),
    .key_level   (level),
    .key_press   (press),
    .key_release (rel),
    .key_strobe  (strobe)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (0),
    .REPEAT_PERIOD   (3)
  ) dut_norep (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .KEY         (key_b),
    .key_level   (level_b),
    .key_press   (press_b),
    .key_release (rel_b),
    .key_strobe  (strobe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key   = 4'hF;
    key_b = 4'hF;
    settle(3);
    checks++;
    if ({level, press, rel, strobe} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0000", {level, press, rel, strobe});
    end
    checks++;
    if ({level_b, press_b, rel_b, strobe_b} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs_norep got %h expected 0000", {level_b, press_b, rel_b, strobe_b});
    end
    rst = 1'b0;
    settle(4);
    checks++;
    if ({level, press, rel, strobe} !== 16'h0) begin
      errors++;
      $display("FAIL idle_after_reset got %h expected 0000", {level, press, rel, strobe});
    end
  endtask

  // Key 0 pressed and held: press at 6, strobes at 6, 16, 19, 22.
  task automatic test_press_repeat();
    logic [3:0] exp_p, exp_l, exp_s;
    key[0] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      step();
      exp_p = (c == 6) ? 4'b0001 : 4'b0000;
      exp_l = (c >= 6) ? 4'b0001 : 4'b0000;
      exp_s = (c == 6 || c == 16 || c == 19 || c == 22) ? 4'b0001 : 4'b0000;
      checks++;
      if (press !== exp_p) begin
        errors++;
        $display("FAIL press_repeat.press c=%0d got %b expected %b", c, press, exp_p);
      end
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL press_repeat.level c=%0d got %b expected %b", c, level, exp_l);
      end
      checks++;
      if (strobe !== exp_s) begin
        errors++;
        $display("FAIL press_repeat.strobe c=%0d got %b expected %b", c, strobe, exp_s);
      end
    end
    key[0] = 1'b1;
    settle(12);
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL press_repeat.released got %b expected 0000", level);
    end
  endtask

  // Key 1 bounces low for 3 cycles, high for 3 cycles, five times.
  task automatic test_bounce();
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 6; c++) begin
        key[1] = (c < 3) ? 1'b0 : 1'b1;
        step();
        checks++;
        if ({level, press, rel, strobe} !== 16'h0) begin
          errors++;
          $display("FAIL bounce b=%0d c=%0d got %h expected 0000", b, c, {level, press, rel, strobe});
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({level, press, rel, strobe} !== 16'h0) begin
        errors++;
        $display("FAIL bounce_tail c=%0d got %h expected 0000", c, {level, press, rel, strobe});
      end
    end
  endtask

  // Key 2 pressed, held through one repeat (at press+10), then released.
  task automatic test_release();
    logic [3:0] exp_r, exp_s, exp_l;
    key[2] = 1'b0;
    settle(6);
    checks++;
    if (press !== 4'b0100) begin
      errors++;
      $display("FAIL release.press got %b expected 0100", press);
    end
    settle(6);
    key[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_r = (c == 6) ? 4'b0100 : 4'b0000;
      exp_s = (c == 4) ? 4'b0100 : 4'b0000;
      exp_l = (c < 6)  ? 4'b0100 : 4'b0000;
      checks++;
      if (rel !== exp_r) begin
        errors++;
        $display("FAIL release.pulse c=%0d got %b expected %b", c, rel, exp_r);
      end
      checks++;
      if (strobe !== exp_s) begin
        errors++;
        $display("FAIL release.strobe c=%0d got %b expected %b", c, strobe, exp_s);
      end
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL release.level c=%0d got %b expected %b", c, level, exp_l);
      end
    end
  endtask

  // All four keys pressed together, then released together.
  task automatic test_simultaneous();
    logic [3:0] exp_v;
    key = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_v = (c == 6) ? 4'hF : 4'h0;
      checks++;
      if (press !== exp_v) begin
        errors++;
        $display("FAIL simul.press c=%0d got %b expected %b", c, press, exp_v);
      end
    end
    key = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_v = (c == 6) ? 4'hF : 4'h0;
      checks++;
      if (rel !== exp_v) begin
        errors++;
        $display("FAIL simul.release c=%0d got %b expected %b", c, rel, exp_v);
      end
    end
    settle(4);
  endtask

  // Reset pulse during a key 0 debounce; key still held afterwards.
  task automatic test_reset_mid();
    logic [3:0] exp_p;
    key[0] = 1'b0;
    settle(3);
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    for (int c = 6; c <= 14; c++) begin
      step();
      exp_p = (c == 11) ? 4'b0001 : 4'b0000;
      checks++;
      if (press !== exp_p) begin
        errors++;
        $display("FAIL reset_mid.press c=%0d got %b expected %b", c, press, exp_p);
      end
    end
    key[0] = 1'b1;
    settle(12);
  endtask

  // With repeat disabled, a 50-cycle hold yields a single strobe.
  task automatic test_no_repeat();
    int n_strobe;
    n_strobe = 0;
    key_b[0] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (strobe_b[0] === 1'b1) n_strobe++;
      if (c == 6) begin
        checks++;
        if (press_b !== 4'b0001) begin
          errors++;
          $display("FAIL no_repeat.press got %b expected 0001", press_b);
        end
      end
    end
    checks++;
    if (n_strobe !== 1) begin
      errors++;
      $display("FAIL no_repeat.count got %0d expected 1", n_strobe);
    end
    checks++;
    if (level_b !== 4'b0001) begin
      errors++;
      $display("FAIL no_repeat.level got %b expected 0001", level_b);
    end
    key_b[0] = 1'b1;
    settle(8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    key    = 4'hF;
    key_b  = 4'hF;
    test_reset();
    test_press_repeat();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_no_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_key_conditioner
`default_nettype wire

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles before a key change is accepted (20 ms at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from press pulse to first repeat pulse; 0 disables repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent repeat pulses; legal range >= 1.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port KEY, input, 4 bits: raw DE-series pushbuttons, active-low, asynchronous to CLOCK_50.
REQ-007 SHALL have port key_level, output, 4 bits: debounced state per key, 1 = pressed.
REQ-008 SHALL have port key_press, output, 4 bits: one-cycle pulse per accepted press.
REQ-009 SHALL have port key_release, output, 4 bits: one-cycle pulse per accepted release.
REQ-010 SHALL have port key_strobe, output, 4 bits: key_press OR auto-repeat pulse; the game logic in main consumes this.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high.
REQ-012 Per key, a counter SHALL increment each cycle the synchronized value differs from key_level and clear to 0 in any cycle they match.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, key_level SHALL toggle at the next edge and the counter SHALL clear.
REQ-014 Latency from a clean KEY edge to key_level change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-015 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-016 key_press/key_release SHALL be registered and high only in the first cycle key_level reads 1/0 after a transition.
REQ-017 Per key, a repeat counter SHALL clear on key_press, count while key_level=1, and clear when key_level=0.
REQ-018 With press pulse at cycle P, repeat pulses SHALL occur at P+REPEAT_DELAY+k*REPEAT_PERIOD, k >= 0, while held; none after release.
REQ-019 Counters SHALL saturate-free wrap only by explicit clear, never by overflow; widths SHALL be $clog2 of their maximum value plus 1.
REQ-020 The four keys SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses.

Reset
REQ-021 While Reset=1: synchronizer flops SHALL load 1 (released); key_level, key_press, key_release, key_strobe SHALL be 0; all counters SHALL be 0.
REQ-022 Reset mid-debounce or mid-repeat SHALL discard progress; a key held through reset SHALL produce key_press DEBOUNCE_CYCLES+2 cycles after Reset falls.

Structure
REQ-023 Default DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD and the NUM_KEYS=4 constant SHALL live in the shared mine_quest package.
REQ-024 Per-key logic SHALL be a sub-module key_debounce_one (synchronizer, debounce, edge pulses, repeat), instantiated NUM_KEYS times.
REQ-025 key_conditioner SHALL sit between top's KEY inputs and main's key input.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 KEY[0] driven 1->0 at cycle 0 and held -> key_level[0]=1 and key_press[0] pulse at cycle 6; strobes at 6, 16, 19, 22.
REQ-027 KEY[1] low for 3 cycles then high, repeated 5 times -> all outputs for key 1 stay 0.
REQ-028 KEY[2] released after press accepted -> key_release[2] pulse exactly 6 cycles after KEY[2] rises; no strobe after.
REQ-029 KEY[3:0]=0000 simultaneously -> four key_press bits pulse in the same cycle.
REQ-030 Reset asserted at cycle 3 of a KEY[0] press, released at cycle 5, key still held -> key_press[0] at cycle 11.
REQ-031 REPEAT_DELAY=0, KEY[0] held 50 cycles -> exactly one key_strobe[0] pulse.
